// File: rtl/booth_pp_accum.sv
// Sequential accumulator for radix-4 Booth 8x8 partial products.
// Optional BOOTH_ACCUM_DUAL_EN: two partial products per cycle.
module booth_pp_accum (
   input  logic        clk,
   input  logic        rst,
   input  logic [8:0]  pp0,
   input  logic [8:0]  pp1,
   input  logic [8:0]  pp2,
   input  logic [8:0]  pp3,
   input  logic [3:0]  n,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [15:0] product,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [3:0][8:0]  r_pp;
   logic [3:0]       r_n;
   logic [15:0]      r_acc;
   logic [15:0]      r_product;
   logic [15:0]      w_add;
   logic [15:0]      w_sum;
   logic             w_last;
   logic             w_accept;
   logic             w_release;

   // Sign-extended, negate-corrected partial product at its weight.
   function automatic logic [15:0] f_term(
      input logic [8:0] pp,
      input logic       neg,
      input logic [2:0] sh
   );
      logic [15:0] v;
      v = {{7{pp[8]}}, pp} + {15'd0, neg};
      return v << sh;
   endfunction

`ifdef BOOTH_ACCUM_DUAL_EN
   logic r_step;

   assign w_last = r_step;
   assign w_add  = f_term(r_pp[{r_step, 1'b0}],
                          r_n[{r_step, 1'b0}],
                          {r_step, 2'b00})
                 + f_term(r_pp[{r_step, 1'b1}],
                          r_n[{r_step, 1'b1}],
                          {r_step, 2'b10});
`else
   logic [1:0] r_step;

   assign w_last = (r_step == 2'd3);
   assign w_add  = f_term(r_pp[r_step],
                          r_n[r_step],
                          {r_step, 1'b0});
`endif

   assign w_sum     = r_acc + w_add;
   assign w_accept  = (r_state == S_IDLE) && in_valid;
   assign w_release = (r_state == S_DONE) && out_ready;

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign product   = r_product;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_accept)  w_next = S_ACCUM;
         S_ACCUM: if (w_last)    w_next = S_DONE;
         S_DONE:  if (w_release) w_next = S_IDLE;
         default:                w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pp      <= '0;
         r_n       <= '0;
         r_acc     <= '0;
         r_step    <= '0;
         r_product <= '0;
      end else begin
         if (w_accept) begin
            r_pp   <= {pp3, pp2, pp1, pp0};
            r_n    <= n;
            r_acc  <= '0;
            r_step <= '0;
         end else if (r_state == S_ACCUM) begin
            r_acc  <= w_sum;
            r_step <= r_step + 1'b1;
            if (w_last) r_product <= w_sum;
         end
      end
   end

endmodule

// File: tb/tb_booth_pp_accum.sv
// Directed self-checking bench for booth_pp_accum.
// Expected latency tracks BOOTH_ACCUM_DUAL_EN.
module tb_booth_pp_accum;

   logic        clk = 1'b0;
   logic        rst;
   logic [8:0]  pp0, pp1, pp2, pp3;
   logic [3:0]  n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] product;
   logic        out_valid;
   logic        out_ready;
   logic        busy;

   int tests = 0;
   int fails = 0;

`ifdef BOOTH_ACCUM_DUAL_EN
   localparam int LAT = 2;
   localparam int GAP = 4;
`else
   localparam int LAT = 4;
   localparam int GAP = 6;
`endif

   booth_pp_accum dut (
      .clk       (clk),
      .rst       (rst),
      .pp0       (pp0),
      .pp1       (pp1),
      .pp2       (pp2),
      .pp3       (pp3),
      .n         (n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .product   (product),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_3x5();
      pp0 = 9'h1FA; pp1 = 9'h005;
      pp2 = 9'h000; pp3 = 9'h000;
      n   = 4'b0001;
   endtask

   task automatic set_m128();
      pp0 = 9'h000; pp1 = 9'h000;
      pp2 = 9'h000; pp3 = 9'h0FF;
      n   = 4'b1000;
   endtask

   // Accept the operands already on the bus; returns edges to out_valid.
   task automatic start_op(output int lat);
      int w;
      w = 0;
      in_valid = 1'b1;
      while (!in_ready && w < 20) begin
         tick();
         w++;
      end
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_in_ready got %b exp 1", in_ready);
      end
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_out_valid got %b exp 0", out_valid);
      end
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_busy got %b exp 0", busy);
      end
      tests++;
      if (product !== 16'h0000) begin
         fails++;
         $display("FAIL reset_product got %h exp 0000", product);
      end
   endtask

   task automatic test_basic();
      int lat;
      out_ready = 1'b1;
      set_3x5();
      start_op(lat);
      tests++;
      if (lat !== LAT) begin
         fails++;
         $display("FAIL basic_latency got %0d exp %0d", lat, LAT);
      end
      tests++;
      if (product !== 16'h000F) begin
         fails++;
         $display("FAIL basic_product got %h exp 000f", product);
      end
      tests++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL basic_done_flags got rdy=%b busy=%b exp 0/1",
                  in_ready, busy);
      end
      tick();
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL basic_release got rdy=%b ov=%b exp 1/0",
                  in_ready, out_valid);
      end
      tests++;
      if (product !== 16'h000F) begin
         fails++;
         $display("FAIL basic_hold got %h exp 000f", product);
      end
   endtask

   task automatic test_corner();
      int lat;
      out_ready = 1'b1;
      set_m128();
      start_op(lat);
      tests++;
      if (product !== 16'h4000 || lat !== LAT) begin
         fails++;
         $display("FAIL corner_m128 got %h lat %0d exp 4000 lat %0d",
                  product, lat, LAT);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int lat;
      out_ready = 1'b0;
      set_3x5();
      start_op(lat);
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (out_valid !== 1'b1 || product !== 16'h000F) begin
            fails++;
            $display("FAIL bp_hold%0d got ov=%b p=%h exp 1/000f",
                     i, out_valid, product);
         end
      end
      out_ready = 1'b1;
      tick();
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL bp_release got ov=%b rdy=%b exp 0/1",
                  out_valid, in_ready);
      end
   endtask

   task automatic test_busy_input();
      int lat;
      out_ready = 1'b1;
      set_3x5();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      set_m128();
      in_valid = 1'b1;
      tests++;
      if (in_ready !== 1'b0) begin
         fails++;
         $display("FAIL busy_in_ready got %b exp 0", in_ready);
      end
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      tests++;
      if (product !== 16'h000F || lat !== LAT) begin
         fails++;
         $display("FAIL busy_product got %h lat %0d exp 000f lat %0d",
                  product, lat, LAT);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int lat;
      out_ready = 1'b1;
      set_m128();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
`ifndef BOOTH_ACCUM_DUAL_EN
      tick();
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
          busy !== 1'b0 || product !== 16'h0000) begin
         fails++;
         $display("FAIL midrst got rdy=%b ov=%b busy=%b p=%h exp 1/0/0/0000",
                  in_ready, out_valid, busy, product);
      end
      set_3x5();
      start_op(lat);
      tests++;
      if (product !== 16'h000F) begin
         fails++;
         $display("FAIL midrst_fresh got %h exp 000f", product);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int          t_acc [2];
      logic [15:0] prods [2];
      int          acc_n;
      int          prod_n;
      logic        hit;
      logic        pv;
      logic [15:0] pq;
      acc_n  = 0;
      prod_n = 0;
      t_acc  = '{0, 0};
      prods  = '{16'h0, 16'h0};
      out_ready = 1'b1;
      set_3x5();
      in_valid = 1'b1;
      for (int c = 0; c < 40 && prod_n < 2; c++) begin
         hit = in_ready && in_valid;
         pv  = out_valid && out_ready;
         pq  = product;
         tick();
         if (hit && acc_n < 2) begin
            t_acc[acc_n] = c;
            acc_n++;
            if (acc_n == 1) set_m128();
            else in_valid = 1'b0;
         end
         if (pv && prod_n < 2) begin
            prods[prod_n] = pq;
            prod_n++;
         end
      end
      in_valid = 1'b0;
      tests++;
      if (acc_n !== 2 || prod_n !== 2) begin
         fails++;
         $display("FAIL b2b_count got acc=%0d prod=%0d exp 2/2",
                  acc_n, prod_n);
      end
      tests++;
      if (t_acc[1] - t_acc[0] !== GAP) begin
         fails++;
         $display("FAIL b2b_gap got %0d exp %0d",
                  t_acc[1] - t_acc[0], GAP);
      end
      tests++;
      if (prods[0] !== 16'h000F) begin
         fails++;
         $display("FAIL b2b_prod0 got %h exp 000f", prods[0]);
      end
      tests++;
      if (prods[1] !== 16'h4000) begin
         fails++;
         $display("FAIL b2b_prod1 got %h exp 4000", prods[1]);
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      pp0 = '0; pp1 = '0; pp2 = '0; pp3 = '0;
      n   = '0;
      test_reset();
      test_basic();
      test_corner();
      test_backpressure();
      test_busy_input();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
